// File: rtl/noc_rr_arbiter.sv
// Packet-aware NoC output arbiter: round-robin or fixed priority,
// registered one-hot grant with optional lock until the tail flit.
module noc_rr_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ARB_MODE       = 0,
   parameter int LOCK_ON_PACKET = 1,
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] req_last,
   input  logic               out_ready,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDW-1:0]     gnt_id,
   output logic               gnt_valid,
   output logic               fire
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [IDW-1:0]     owner_q, owner_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;

   logic [IDW-1:0] ptr_nxt;
   logic [IDW:0]   pick_cur, pick_rel;
   logic           release_w;

   // Returns {found, index}; scanning downward lets the lowest offset win.
   function automatic logic [IDW:0] arb(input logic [NUM_REQ-1:0] r,
                                        input logic [IDW-1:0] p);
      logic [IDW:0]   res;
      logic [IDW-1:0] idx;
      int             j;
      res = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = (ARB_MODE == 1) ? i : int'(p) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         idx = IDW'(j);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign gnt_valid = (state_q == BUSY);
   assign gnt       = gnt_q;
   assign gnt_id    = owner_q;
   assign fire      = gnt_valid & req[owner_q] & out_ready;

   assign ptr_nxt  = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
   assign pick_cur = arb(req, ptr_q);
   assign pick_rel = arb(req, ptr_nxt);

   // An owner that drops req aborts its packet; fire is low then.
   assign release_w = !req[owner_q] |
                      (fire & (req_last[owner_q] | (LOCK_ON_PACKET == 0)));

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (pick_cur[IDW]) begin
               state_d = BUSY;
               owner_d = pick_cur[IDW-1:0];
            end
         end
         BUSY: begin
            if (release_w) begin
               ptr_d = ptr_nxt;
               if (pick_rel[IDW]) begin
                  owner_d = pick_rel[IDW-1:0];
               end else begin
                  state_d = IDLE;
                  owner_d = '0;
               end
            end
         end
      endcase
      gnt_d = '0;
      if (state_d == BUSY) gnt_d[owner_d] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
      end
   end

endmodule

// File: doc/noc_rr_arbiter.md
NOC_RR_ARBITER -- requirements
Module: noc_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal range 1..32).
REQ-002 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority with index 0 highest.
REQ-003 SHALL have parameter LOCK_ON_PACKET, default 1: 1 = hold the grant until the tail flit, 0 = release after every flit.
REQ-004 SHALL derive localparam IDW = max(1, $clog2(NUM_REQ)).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port req, input, NUM_REQ bits: per-requester flit-valid.
REQ-008 SHALL have port req_last, input, NUM_REQ bits: per-requester tail-flit marker, qualified by req.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts the granted flit.
REQ-010 SHALL have port gnt, output, NUM_REQ bits: one-hot grant, or all zero.
REQ-011 SHALL have port gnt_id, output, IDW bits: binary index of the owner.
REQ-012 SHALL have port gnt_valid, output, 1 bit: a grant is active.
REQ-013 SHALL have port fire, output, 1 bit: a flit transfers this cycle.

Function
REQ-014 SHALL implement two states: IDLE and BUSY.
REQ-015 SHALL drive gnt, gnt_id and gnt_valid from registers only; there is no combinational path from req to gnt.
REQ-016 SHALL, in IDLE with any req bit set, select a winner w and enter BUSY next cycle with owner=w, giving a grant latency of 1 cycle.
REQ-017 SHALL, in round-robin mode, select the first set req bit scanning upward from ptr and wrapping modulo NUM_REQ.
REQ-018 SHALL, in fixed-priority mode, select the lowest set req index; ptr is maintained but ignored.
REQ-019 SHALL, in BUSY, assert gnt[owner]=1, gnt_id=owner and gnt_valid=1.
REQ-020 SHALL compute fire = gnt_valid & req[owner] & out_ready.
REQ-021 SHALL release the grant when fire & (req_last[owner] | !LOCK_ON_PACKET).
REQ-022 SHALL release the grant when req[owner]=0 in BUSY (requester abort); fire=0 in that cycle.
REQ-023 SHALL, on release, set ptr <= (owner+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-024 SHALL, in the release cycle, arbitrate over the current req using the updated ptr. If any bit is set, it stays in BUSY with the new owner next cycle (no bubble); otherwise it goes to IDLE.
REQ-025 SHALL hold owner, ptr and gnt unchanged while out_ready=0, even with req_last asserted.
REQ-026 SHALL ignore req_last when req is low, and ignore req_last of non-owners.
REQ-027 SHALL, when NUM_REQ=1, always grant index 0 with gnt_id=0 and ptr constant at 0.
REQ-028 SHALL never assert more than one gnt bit, and gnt_valid SHALL equal |gnt.

Reset
REQ-029 SHALL, on rst=1 and without waiting for a clock edge, force state=IDLE, ptr=0, owner=0, gnt=0, gnt_id=0, gnt_valid=0 and fire=0.
REQ-030 SHALL, on rst assertion mid-packet, abandon the packet with no release bookkeeping.
REQ-031 SHALL, on the first rising edge after rst deasserts, arbitrate as from IDLE with ptr=0.

Verification (NUM_REQ=4 unless stated)
REQ-032 SHALL cover: RR, after reset, req=1010, all last=1, ready=1 -> next cycle gnt=0010, gnt_id=1; next cycle gnt=1000.
REQ-033 SHALL cover: RR, req=1111 held, all last=1, ready=1 -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles with no idle cycle.
REQ-034 SHALL cover: RR, LOCK=1, owner 2 with a 3-flit packet (last on flit 3) and req[0]=1 throughout -> gnt=0100 for exactly 3 fires, then 0001 the following cycle.
REQ-035 SHALL cover: out_ready=0 for 5 cycles with owner's req_last=1 -> gnt unchanged and fire=0 throughout; first cycle of ready=1 -> fire=1, then the grant releases.
REQ-036 SHALL cover: fixed mode, current owner 3, req changes to 1001 mid-packet -> after the tail, gnt=0001, and owner 3 re-wins only when req[0]=0.
REQ-037 SHALL cover: rst pulsed between edges during a BUSY packet -> gnt=0 and gnt_valid=0 immediately; after release with req=1111, first gnt=0001.
